// File: rtl/pipelined_rca_adder.sv
// ---------------------------------------------------------------------------
// pipelined_rca_adder
//
// Purpose:
//   WIDTH-bit two's-complement / unsigned adder whose ripple-carry chain is cut
//   into STAGES chunks of CHUNK = WIDTH/STAGES bits. Each stage adds one chunk
//   and registers its carry. Operand bits that have not been added yet travel
//   down a skew chain. Finished low sum bits travel down a deskew chain, so a
//   complete result appears at the output in one piece. A new addition can be
//   accepted every cycle, and the valid/ready handshakes allow back-pressure.
//
// Parameters:
//   WIDTH  - operand/sum width; a multiple of STAGES, at least 2
//   STAGES - pipeline depth (= latency in cycles), 1..WIDTH
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous reset, active-high
//   in_valid  - a/b/cin are valid this cycle
//   in_ready  - the adder accepts input this cycle (~out_valid | out_ready)
//   a, b      - operands
//   cin       - carry into bit 0
//   out_valid - sum/cout/overflow are valid
//   out_ready - downstream accepts the result
//   sum       - a + b + cin modulo 2^WIDTH
//   cout      - unsigned carry out of bit WIDTH-1
//   overflow  - signed overflow flag
//
// Optional feature (compile-time macro PIPELINED_RCA_SATURATE_EN):
//   When the macro is defined, sum is clamped to the signed limit whenever
//   overflow=1. cout and overflow still report the raw result. The operand
//   sign bits are already in the last chunk, so clamping needs no extra
//   registers.
// ---------------------------------------------------------------------------
module pipelined_rca_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  // The whole pipeline moves as a unit. Bubbles are not squeezed out, so a
  // single enable covers every stage.
  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;   // first bit handled by this stage
    localparam int HI = LO + CHUNK;  // number of sum bits complete after it

    // a_src/b_src hold operand bits [WIDTH-1:LO]. Their low CHUNK bits are
    // this stage's chunk.
    logic [WIDTH-LO-1:0] a_src;
    logic [WIDTH-LO-1:0] b_src;
    logic                c_src;
    logic                v_src;
    logic [CHUNK:0]      chunk_sum;
    logic [HI-1:0]       s_next;
    logic [HI-1:0]       s_load;

    logic                v_q;
    logic                c_q;
    logic [HI-1:0]       s_q;

    if (k == 0) begin : g_src
      assign a_src  = a;
      assign b_src  = b;
      assign c_src  = cin;
      assign v_src  = in_valid;
      assign s_next = chunk_sum[CHUNK-1:0];
    end else begin : g_src
      assign a_src  = g_stage[k-1].g_fwd.a_q;
      assign b_src  = g_stage[k-1].g_fwd.b_q;
      assign c_src  = g_stage[k-1].c_q;
      assign v_src  = g_stage[k-1].v_q;
      assign s_next = {chunk_sum[CHUNK-1:0], g_stage[k-1].s_q};
    end

    assign chunk_sum = {1'b0, a_src[CHUNK-1:0]}
                     + {1'b0, b_src[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, c_src};

    if (k < STAGES - 1) begin : g_fwd
      // Skew chain: operand bits that later stages still have to add.
      logic [WIDTH-HI-1:0] a_q;
      logic [WIDTH-HI-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_src[WIDTH-LO-1:CHUNK];
          b_q <= b_src[WIDTH-LO-1:CHUNK];
        end
      end

      assign s_load = s_next;
    end else begin : g_last
      logic sign_a;
      logic sign_b;
      logic sign_s;
      logic c_msb;
      logic ovf_next;
      logic ovf_q;

      assign sign_a   = a_src[CHUNK-1];
      assign sign_b   = b_src[CHUNK-1];
      assign sign_s   = chunk_sum[CHUNK-1];
      // The MSB sum bit is a ^ b ^ carry_in, so carry_in can be recovered
      // from the three bits. This avoids splitting the last chunk's adder.
      assign c_msb    = sign_a ^ sign_b ^ sign_s;
      assign ovf_next = c_msb ^ chunk_sum[CHUNK];

`ifdef PIPELINED_RCA_SATURATE_EN
      // Overflow only happens when both operands have the same sign, so the
      // sign of a alone selects the limit.
      assign s_load = ovf_next ? {sign_a, {(WIDTH-1){~sign_a}}} : s_next;
`else
      assign s_load = s_next;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_next;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_src;
        c_q <= chunk_sum[CHUNK];
        s_q <= s_load;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
module tb_pipelined_rca_adder;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;
  logic [33:0] exp_q[$];  // {sum, cout, overflow}

  always #5 clk = ~clk;

  pipelined_rca_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    logic [32:0] t;
    logic [31:0] s;
    logic        v;
    t = {1'b0, x} + {1'b0, y} + {32'b0, c};
    s = t[31:0];
    v = (x[31] == y[31]) && (s[31] != x[31]);
`ifdef PIPELINED_RCA_SATURATE_EN
    if (v) s = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {s, t[32], v};
  endfunction

  // Drives one cycle of stimulus just after a falling edge. If the input is
  // accepted, the expected result is queued.
  task automatic drive(input logic iv, input logic [31:0] av, input logic [31:0] bv,
                       input logic cv, input logic ordy, input logic [33:0] want,
                       output logic acc);
    in_valid  = iv;
    a         = av;
    b         = bv;
    cin       = cv;
    out_ready = ordy;
    #1;
    acc = iv & in_ready;
    if (acc) exp_q.push_back(want);
  endtask

  task automatic test_reset;
    logic acc;
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, '0, acc);
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (sum !== 32'h0) begin n_err++; $display("FAIL reset_sum: got %h want 0", sum); end
    n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b want 0", cout); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_vectors;
    logic [31:0] va[5];
    logic [31:0] vb[5];
    logic        vc[5];
    logic [33:0] ve[5];
    va = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h00FF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
    vb = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001};
    vc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`ifdef PIPELINED_RCA_SATURATE_EN
    ve[0] = {32'h7FFF_FFFF, 1'b0, 1'b1};
    ve[1] = {32'h8000_0000, 1'b1, 1'b1};
`else
    ve[0] = {32'h8000_0000, 1'b0, 1'b1};
    ve[1] = {32'h7FFF_FFFF, 1'b1, 1'b1};
`endif
    ve[2] = {32'h0100_0000, 1'b0, 1'b0};
    ve[3] = {32'h0000_0000, 1'b1, 1'b0};
    ve[4] = {32'h0001_0000, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      logic        acc;
      int          lat;
      logic [33:0] want;
      drive(1'b1, va[i], vb[i], vc[i], 1'b1, ve[i], acc);
      n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL vec%0d_accept: got %b want 1", i, acc); end
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, '0, acc);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 12) begin
        @(negedge clk);
        #1;
        lat++;
      end
      n_vec++; if (lat != STAGES) begin n_err++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, STAGES); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        n_vec++;
        if ({sum, cout, overflow} !== want) begin
          n_err++;
          $display("FAIL vec%0d_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                   i, sum, cout, overflow, want[33:2], want[1], want[0]);
        end
      end else begin
        exp_q.delete();
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int          first;
    int          last;
    int          nvalid;
    logic        acc;
    logic [31:0] av;
    logic [31:0] bv;
    logic [33:0] want;
    first = -1; last = -1; nvalid = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < 8) begin
        av = 32'(c * 1000);
        bv = 32'(-(c * 3));
        drive(1'b1, av, bv, 1'b0, 1'b1, model(av, bv, 1'b0), acc);
        n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL b2b_accept%0d: got %b want 1", c, acc); end
      end else begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, '0, acc);
      end
      if (out_valid === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        nvalid++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra_output: got sum=%h want none", sum);
        end else begin
          want = exp_q.pop_front();
          if ({sum, cout, overflow} !== want) begin
            n_err++;
            $display("FAIL b2b_result: got %h/%b/%b want %h/%b/%b",
                     sum, cout, overflow, want[33:2], want[1], want[0]);
          end
        end
      end
      @(negedge clk);
    end
    n_vec++; if (first != STAGES) begin n_err++; $display("FAIL b2b_first: got %0d want %0d", first, STAGES); end
    n_vec++; if (last != STAGES + 7) begin n_err++; $display("FAIL b2b_last: got %0d want %0d", last, STAGES + 7); end
    n_vec++; if (nvalid != 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", nvalid); end
    exp_q.delete();
  endtask

  task automatic test_backpressure;
    int          sent;
    int          got_n;
    logic        ordy;
    logic        acc;
    logic        cv;
    logic [31:0] av;
    logic [31:0] bv;
    logic [33:0] held;
    logic [33:0] want;
    sent = 0; got_n = 0; held = '0;
    for (int c = 0; c < 30 && got_n < 6; c++) begin
      ordy = !(c >= 5 && c <= 7);
      av = $urandom;
      bv = $urandom;
      cv = 1'($urandom_range(0, 1));
      drive(sent < 6, av, bv, cv, ordy, model(av, bv, cv), acc);
      if (acc) sent++;
      if (!ordy) begin
        n_vec++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
          n_err++; $display("FAIL bp_stall%0d: got out_valid=%b in_ready=%b want 1/0", c, out_valid, in_ready);
        end
        if (c == 5) begin
          held = {sum, cout, overflow};
        end else begin
          n_vec++;
          if ({sum, cout, overflow} !== held) begin
            n_err++; $display("FAIL bp_hold%0d: got %h want %h", c, {sum, cout, overflow}, held);
          end
        end
      end else if (out_valid === 1'b1) begin
        got_n++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL bp_extra_output: got sum=%h want none", sum);
        end else begin
          want = exp_q.pop_front();
          if ({sum, cout, overflow} !== want) begin
            n_err++; $display("FAIL bp_result%0d: got %h want %h", got_n, {sum, cout, overflow}, want);
          end
        end
      end
      @(negedge clk);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, '0, acc);
    n_vec++; if (got_n != 6) begin n_err++; $display("FAIL bp_delivered: got %0d want 6", got_n); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    logic        acc;
    logic        cv;
    int          lat;
    logic [31:0] av;
    logic [31:0] bv;
    logic [33:0] want;
    for (int c = 0; c < 3; c++) begin
      av = $urandom; bv = $urandom;
      drive(1'b1, av, bv, 1'b0, 1'b1, model(av, bv, 1'b0), acc);
      n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL rstmid_accept%0d: got %b want 1", c, acc); end
      @(negedge clk);
    end
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, '0, acc);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, '0, acc);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_ghost%0d: got out_valid=%b want 0", c, out_valid); end
      @(negedge clk);
    end
    av = 32'h1234_5678; bv = 32'h8765_4321; cv = 1'b1;
    drive(1'b1, av, bv, cv, 1'b1, model(av, bv, cv), acc);
    n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL rstmid_accept_new: got %b want 1", acc); end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, '0, acc);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      #1;
      lat++;
    end
    n_vec++; if (lat != STAGES) begin n_err++; $display("FAIL rstmid_latency: got %0d want %0d", lat, STAGES); end
    if (out_valid === 1'b1 && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_vec++;
      if ({sum, cout, overflow} !== want) begin
        n_err++; $display("FAIL rstmid_result: got %h want %h", {sum, cout, overflow}, want);
      end
    end
    @(negedge clk);
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
